// File: rtl/framebuf_scanout_pkg.sv
// Shared constants and FSM state encoding for the FrameBuf scan-out read master.
package framebuf_scanout_pkg;
  localparam int FB_ADDR_W     = 13;
  localparam int FB_DATA_W     = 16;
  localparam int FB_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;
endpackage

// File: rtl/framebuf_scanout_skid_fifo.sv
// Two-entry skid FIFO holding RAM read data until the pixel stream accepts it.
// Entry 0 is always the head of the queue.
module framebuf_scanout_skid_fifo
  import framebuf_scanout_pkg::*;
#(
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem0_q, mem0_d;
  logic [DATA_W-1:0] mem1_q, mem1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) mem0_d = din;
          else                 mem1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
        // Simultaneous push and pop: the queue shifts and the count holds.
        2'b11: begin
          if (count_q == 2'd1) begin
            mem0_d = din;
          end else begin
            mem0_d = mem1_q;
            mem1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem0_q;
endmodule

// File: rtl/framebuf_scanout.sv
// Read-side master for FrameBuf port s2: scans FRAME_WORDS words from BASE_ADDR
// upward and presents them in address order as a valid/ready pixel stream.
module framebuf_scanout
  import framebuf_scanout_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int FRAME_WORDS = 8192,
  parameter int BASE_ADDR   = 0
) (
  input  logic              mem_clk_clk,
  input  logic              mem_rst_reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_s2_address,
  output logic              mem_s2_chipselect,
  output logic              mem_s2_clken,
  output logic              mem_s2_write,
  output logic [DATA_W-1:0] mem_s2_writedata,
  output logic [1:0]        mem_s2_byteenable,
  input  logic [DATA_W-1:0] mem_s2_readdata,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready
);
  localparam logic [ADDR_W-1:0] BASE_W        = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   FRAME_WORDS_W = (ADDR_W + 1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0]   ONE_WORD      = (ADDR_W + 1)'(1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic       pop, push, flush, issue;

  assign px_valid = (fifo_count != 2'd0);
  assign pop      = px_valid && px_ready;
  assign flush    = abort && (state_q != ST_IDLE);
  assign push     = inflight_q && !flush;

  // A word popped this cycle frees its slot at the same edge the next read lands,
  // so it is subtracted from the occupancy to keep issue at full rate.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_SCAN) && !abort && (occupancy < 3'd2);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    inflight_d   = issue;
    unique case (state_q)
      ST_IDLE: begin
        // busy_q is still high in the frame_done cycle, which blocks a restart there.
        busy_d = 1'b0;
        if (start && !abort && !busy_q) begin
          state_d      = ST_SCAN;
          busy_d       = 1'b1;
          addr_d       = BASE_W;
          words_left_d = FRAME_WORDS_W;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (issue) begin
          addr_d       = addr_q + 1'b1;
          words_left_d = words_left_q - ONE_WORD;
          if (words_left_q == ONE_WORD) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk_clk or posedge mem_rst_reset) begin
    if (mem_rst_reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE_W;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  framebuf_scanout_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (mem_clk_clk),
    .rst   (mem_rst_reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mem_s2_readdata),
    .count (fifo_count),
    .head  (px_data)
  );

  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign mem_s2_address    = addr_q;
  assign mem_s2_chipselect = issue;
  assign mem_s2_clken      = issue;
  assign mem_s2_write      = 1'b0;
  assign mem_s2_writedata  = '0;
  assign mem_s2_byteenable = 2'b11;
endmodule

// File: tb/tb_framebuf_scanout.sv
// Bench for framebuf_scanout: five instances with different frame sizes/bases,
// each backed by a 1-cycle RAM model returning word[a] = a ^ 16'hA5A5.
module tb_framebuf_scanout;
  localparam int N_DUT = 5;

  function automatic int fw_of(input int i);
    case (i)
      0:       return 8;
      1:       return 16;
      2:       return 4;
      3:       return 1;
      default: return 8192;
    endcase
  endfunction

  function automatic int base_of(input int i);
    return (i == 2) ? 'h1FFE : 0;
  endfunction

  typedef struct {
    int          idx;
    int          nwords;
    int          mode;
    logic [12:0] base;
    logic [15:0] first_word;
    logic [15:0] last_word;
    int          first_k;
    int          done_k;
  } scan_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [N_DUT];
  logic        abort      [N_DUT];
  logic        px_ready   [N_DUT];
  logic        busy       [N_DUT];
  logic        frame_done [N_DUT];
  logic        cs         [N_DUT];
  logic        clken      [N_DUT];
  logic        wr         [N_DUT];
  logic        px_valid   [N_DUT];
  logic [12:0] addr       [N_DUT];
  logic [15:0] wdata      [N_DUT];
  logic [15:0] rdata      [N_DUT];
  logic [15:0] px_data    [N_DUT];
  logic [1:0]  be         [N_DUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    framebuf_scanout #(
      .ADDR_W      (13),
      .DATA_W      (16),
      .FRAME_WORDS (fw_of(g)),
      .BASE_ADDR   (base_of(g))
    ) u_dut (
      .mem_clk_clk       (clk),
      .mem_rst_reset     (rst),
      .start             (start[g]),
      .abort             (abort[g]),
      .busy              (busy[g]),
      .frame_done        (frame_done[g]),
      .mem_s2_address    (addr[g]),
      .mem_s2_chipselect (cs[g]),
      .mem_s2_clken      (clken[g]),
      .mem_s2_write      (wr[g]),
      .mem_s2_writedata  (wdata[g]),
      .mem_s2_byteenable (be[g]),
      .mem_s2_readdata   (rdata[g]),
      .px_data           (px_data[g]),
      .px_valid          (px_valid[g]),
      .px_ready          (px_ready[g])
    );

    always @(posedge clk) begin
      if (cs[g]) rdata[g] <= {3'b000, addr[g]} ^ 16'hA5A5;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return (k % 4 == 1) || (k % 4 == 0);
  endfunction

  // Runs one full frame on instance v.idx, checking addresses, data order, credits,
  // stall stability and frame_done; also pulses start in the frame_done cycle.
  task automatic applyStimulus(input scan_vec_t v, input string name);
    int i, issued, xfer, done_cnt, addr_err, data_err, credit_err, stall_err, clk_err;
    int first_k, done_k, budget, busy_at_done, post_busy;
    logic finished, xfer_now, prev_stall;
    logic [15:0] first_w, last_w, prev_data, exp_w;
    logic [12:0] exp_a;
    i = v.idx; issued = 0; xfer = 0; done_cnt = 0; addr_err = 0; data_err = 0;
    credit_err = 0; stall_err = 0; clk_err = 0; first_k = -1; done_k = -1;
    busy_at_done = 0; post_busy = 1; finished = 1'b0; prev_stall = 1'b0;
    prev_data = '0; first_w = '0; last_w = '0;
    budget = v.nwords * 4 + 40;
    @(negedge clk);
    start[i] = 1'b1;
    px_ready[i] = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start[i] = 1'b0;
      px_ready[i] = ready_for(v.mode, k);
      #1;
      xfer_now = px_valid[i] && px_ready[i];
      if (cs[i]) begin
        if (clken[i] !== 1'b1) clk_err++;
        exp_a = v.base + 13'(issued);
        if (addr[i] !== exp_a) addr_err++;
        if (issued - xfer - (xfer_now ? 1 : 0) >= 2) credit_err++;
        issued++;
      end
      if (prev_stall && (px_valid[i] !== 1'b1 || px_data[i] !== prev_data)) stall_err++;
      if (xfer_now) begin
        exp_w = {3'b000, v.base + 13'(xfer)} ^ 16'hA5A5;
        if (px_data[i] !== exp_w) data_err++;
        if (xfer == 0) begin
          first_w = px_data[i];
          first_k = k;
        end
        last_w = px_data[i];
        xfer++;
      end
      prev_stall = px_valid[i] && !px_ready[i];
      prev_data  = px_data[i];
      if (frame_done[i] === 1'b1) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = busy[i];
          start[i] = 1'b1;
        end
      end
      if (done_k >= 0 && k == done_k + 1) post_busy = busy[i];
      if (done_k >= 0 && k == done_k + 3) begin
        finished = 1'b1;
        break;
      end
    end
    start[i] = 1'b0;
    checkOutput({name, " finished"}, 32'(finished), 32'd1);
    checkOutput({name, " reads issued"}, 32'(issued), 32'(v.nwords));
    checkOutput({name, " transfers"}, 32'(xfer), 32'(v.nwords));
    checkOutput({name, " frame_done pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({name, " address errors"}, 32'(addr_err), 32'd0);
    checkOutput({name, " data order errors"}, 32'(data_err), 32'd0);
    checkOutput({name, " credit violations"}, 32'(credit_err), 32'd0);
    checkOutput({name, " stall instability"}, 32'(stall_err), 32'd0);
    checkOutput({name, " clken mismatch"}, 32'(clk_err), 32'd0);
    checkOutput({name, " first word"}, 32'(first_w), 32'(v.first_word));
    checkOutput({name, " last word"}, 32'(last_w), 32'(v.last_word));
    checkOutput({name, " busy in done cycle"}, 32'(busy_at_done), 32'd1);
    checkOutput({name, " busy after done"}, 32'(post_busy), 32'd0);
    if (v.first_k >= 0) checkOutput({name, " first transfer cycle"}, 32'(first_k), 32'(v.first_k));
    if (v.done_k >= 0) checkOutput({name, " frame_done cycle"}, 32'(done_k), 32'(v.done_k));
  endtask

  scan_vec_t vecs [5];

  initial begin
    int xfer, seen, stray;
    vecs[0] = '{0, 8,    0, 13'h0000, 16'hA5A5, 16'hA5A2, 3, 12};
    vecs[1] = '{1, 16,   1, 13'h0000, 16'hA5A5, 16'hA5AA, 4, -1};
    vecs[2] = '{2, 4,    0, 13'h1FFE, 16'hBA5B, 16'hA5A4, 3, 8};
    vecs[3] = '{3, 1,    0, 13'h0000, 16'hA5A5, 16'hA5A5, 3, 5};
    vecs[4] = '{4, 8192, 0, 13'h0000, 16'hA5A5, 16'hBA5A, 3, 8196};

    rst = 1'b1;
    for (int i = 0; i < N_DUT; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      px_ready[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      checkOutput($sformatf("reset busy[%0d]", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("reset px_valid[%0d]", i), 32'(px_valid[i]), 32'd0);
      checkOutput($sformatf("reset chipselect[%0d]", i), 32'(cs[i]), 32'd0);
      checkOutput($sformatf("reset clken[%0d]", i), 32'(clken[i]), 32'd0);
      checkOutput($sformatf("reset frame_done[%0d]", i), 32'(frame_done[i]), 32'd0);
      checkOutput($sformatf("reset address[%0d]", i), 32'(addr[i]), 32'(base_of(i)));
      checkOutput($sformatf("write const[%0d]", i), 32'(wr[i]), 32'd0);
      checkOutput($sformatf("writedata const[%0d]", i), 32'(wdata[i]), 32'd0);
      checkOutput($sformatf("byteenable const[%0d]", i), 32'(be[i]), 32'd3);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) applyStimulus(vecs[t], $sformatf("scan%0d", t));

    // Abort one cycle after the third transfer, then rescan from the base.
    @(negedge clk);
    start[0] = 1'b1;
    px_ready[0] = 1'b1;
    xfer = 0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      #1;
      if (px_valid[0] && px_ready[0]) xfer++;
      if (xfer == 3) begin
        seen = 1;
        break;
      end
    end
    checkOutput("abort third transfer reached", 32'(seen), 32'd1);
    @(negedge clk);
    abort[0] = 1'b1;
    #1;
    checkOutput("abort cycle px_valid", 32'(px_valid[0]), 32'd1);
    checkOutput("abort cycle px_data", 32'(px_data[0]), 32'hA5A6);
    checkOutput("abort cycle chipselect", 32'(cs[0]), 32'd0);
    @(negedge clk);
    abort[0] = 1'b0;
    #1;
    checkOutput("after abort px_valid", 32'(px_valid[0]), 32'd0);
    checkOutput("after abort busy", 32'(busy[0]), 32'd0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (frame_done[0] || cs[0] || px_valid[0] || busy[0]) stray++;
    end
    checkOutput("after abort quiet", 32'(stray), 32'd0);
    applyStimulus(vecs[0], "rescan");

    // Asynchronous reset off the clock edge in the middle of a scan.
    @(negedge clk);
    start[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    #2;
    checkOutput("pre-reset busy", 32'(busy[0]), 32'd1);
    checkOutput("pre-reset px_valid", 32'(px_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(busy[0]), 32'd0);
    checkOutput("async reset px_valid", 32'(px_valid[0]), 32'd0);
    checkOutput("async reset chipselect", 32'(cs[0]), 32'd0);
    checkOutput("async reset clken", 32'(clken[0]), 32'd0);
    checkOutput("async reset frame_done", 32'(frame_done[0]), 32'd0);
    checkOutput("async reset address", 32'(addr[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start together with abort: abort wins.
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      abort[0] = 1'b0;
      #1;
      if (busy[0] || cs[0] || px_valid[0]) stray++;
    end
    checkOutput("start+abort stays idle", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
